// File: rtl/decode_stream_ctrl.sv
// decode_stream_ctrl
//   Stream controller between the encoded-word RAM, the entropy decoder and the
//   decoded-sample RAM. A word FSM fetches encoded words over a 1-cycle-latency
//   read port and offers them to the decoder with valid/ready. A concurrent
//   sample path writes decoded samples sequentially to the output RAM, counts
//   completed BLOCK_LEN-sample blocks and ends the frame at OUT_DEPTH samples.
//   Optional feature macro: DSC_CHECKSUM_EN adds chk_o, a 16-bit running sum of
//   all accepted samples in the current frame.
module decode_stream_ctrl #(
    parameter int IN_W      = 32,
    parameter int IN_AW     = 13,
    parameter int OUT_W     = 8,
    parameter int OUT_DEPTH = 76800,
    parameter int OUT_AW    = 17,
    parameter int BLOCK_LEN = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [IN_AW-1:0]  in_words_i,
    output logic              in_en_o,
    output logic [IN_AW-1:0]  in_addr_o,
    input  logic [IN_W-1:0]   in_data_i,
    output logic [IN_W-1:0]   dec_data_o,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    input  logic [OUT_W-1:0]  dec_samp_i,
    input  logic              dec_samp_valid_i,
    output logic              dec_samp_ready_o,
    output logic              out_we_o,
    output logic [OUT_AW-1:0] out_addr_o,
    output logic [OUT_W-1:0]  out_data_o,
    output logic [OUT_AW-1:0] blk_cnt_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o
`ifdef DSC_CHECKSUM_EN
    ,
    output logic [15:0]       chk_o
`endif
);

    // One extra bit so the write pointer can hold OUT_DEPTH even when
    // OUT_DEPTH == 2**OUT_AW.
    localparam int WP_W = OUT_AW + 1;
    localparam int BP_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    localparam logic [WP_W-1:0] DEPTH     = WP_W'(OUT_DEPTH);
    localparam logic [WP_W-1:0] LAST_SAMP = WP_W'(OUT_DEPTH - 1);
    localparam logic [BP_W-1:0] BP_LAST   = BP_W'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_OFFER,
        S_EXHAUSTED,
        S_DONE
    } state_e;

    // Word FSM registers
    state_e            state_q;
    logic [IN_AW-1:0]  in_words_q;
    logic [IN_AW-1:0]  rd_ptr_q;
    logic [IN_AW-1:0]  rd_nxt;
    logic              in_en_q;
    logic [IN_AW-1:0]  in_addr_q;
    logic [IN_W-1:0]   dec_data_q;
    logic              dec_valid_q;
    logic              busy_q;
    logic              done_q;
    logic              underrun_q;

    // Sample path registers
    logic [WP_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [BP_W-1:0]   blk_pos_q,  blk_pos_d;
    logic [OUT_AW-1:0] blk_cnt_q,  blk_cnt_d;
    logic              out_we_q,   out_we_d;
    logic [OUT_AW-1:0] out_addr_q, out_addr_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
`ifdef DSC_CHECKSUM_EN
    logic [15:0]       chk_q,      chk_d;
`endif

    logic frame_start;
    logic samp_accept;
    logic last_accept;

    assign frame_start      = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign dec_samp_ready_o = busy_q && (wr_ptr_q < DEPTH);
    assign samp_accept      = dec_samp_valid_i && dec_samp_ready_o;
    assign last_accept      = samp_accept && (wr_ptr_q == LAST_SAMP);
    assign rd_nxt           = rd_ptr_q + 1'b1;

    // Word FSM: fetch, capture, offer each encoded word; frame end overrides all.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            in_words_q  <= '0;
            rd_ptr_q    <= '0;
            in_en_q     <= 1'b0;
            in_addr_q   <= '0;
            dec_data_q  <= '0;
            dec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        in_words_q <= in_words_i;
                        rd_ptr_q   <= '0;
                        done_q     <= 1'b0;
                        underrun_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (in_words_i == '0) begin
                            state_q <= S_EXHAUSTED;
                        end else begin
                            state_q   <= S_FETCH;
                            in_en_q   <= 1'b1;
                            in_addr_q <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    in_en_q <= 1'b0;
                    state_q <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    dec_data_q  <= in_data_i;
                    dec_valid_q <= 1'b1;
                    state_q     <= S_OFFER;
                end
                S_OFFER: begin
                    if (dec_ready_i) begin
                        dec_valid_q <= 1'b0;
                        rd_ptr_q    <= rd_nxt;
                        if (rd_nxt == in_words_q) begin
                            state_q <= S_EXHAUSTED;
                        end else begin
                            state_q   <= S_FETCH;
                            in_en_q   <= 1'b1;
                            in_addr_q <= rd_nxt;
                        end
                    end
                end
                S_EXHAUSTED: begin
                    if (dec_ready_i) begin
                        underrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase

            // The last sample ends the frame regardless of where the word FSM is;
            // a word handshake in the same cycle still advances rd_ptr above.
            if (last_accept) begin
                state_q     <= S_DONE;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                dec_valid_q <= 1'b0;
                in_en_q     <= 1'b0;
            end
        end
    end

    // Sample path next state: sequential write, block counting, optional checksum.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        blk_pos_d  = blk_pos_q;
        blk_cnt_d  = blk_cnt_q;
        out_we_d   = 1'b0;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
`ifdef DSC_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        if (frame_start) begin
            wr_ptr_d  = '0;
            blk_pos_d = '0;
            blk_cnt_d = '0;
`ifdef DSC_CHECKSUM_EN
            chk_d     = '0;
`endif
        end else if (samp_accept) begin
            out_we_d   = 1'b1;
            out_addr_d = wr_ptr_q[OUT_AW-1:0];
            out_data_d = dec_samp_i;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            if (blk_pos_q == BP_LAST) begin
                blk_pos_d = '0;
                blk_cnt_d = blk_cnt_q + 1'b1;
            end else begin
                blk_pos_d = blk_pos_q + 1'b1;
            end
`ifdef DSC_CHECKSUM_EN
            chk_d = chk_q + 16'(dec_samp_i);
`endif
        end
    end

    // Sample path registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            blk_pos_q  <= '0;
            blk_cnt_q  <= '0;
            out_we_q   <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
`ifdef DSC_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            blk_pos_q  <= blk_pos_d;
            blk_cnt_q  <= blk_cnt_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
`ifdef DSC_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign in_en_o     = in_en_q;
    assign in_addr_o   = in_addr_q;
    assign dec_data_o  = dec_data_q;
    assign dec_valid_o = dec_valid_q;
    assign out_we_o    = out_we_q;
    assign out_addr_o  = out_addr_q;
    assign out_data_o  = out_data_q;
    assign blk_cnt_o   = blk_cnt_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign underrun_o  = underrun_q;
`ifdef DSC_CHECKSUM_EN
    assign chk_o       = chk_q;
`endif

endmodule

// File: tb/tb_decode_stream_ctrl.sv
// Testbench for decode_stream_ctrl (small frame: 128 samples, 64-sample blocks).
// The reference model tracks the frame in terms of words consumed, samples
// accepted and the fixed 3-cycle fetch/capture/offer latency; every output is
// compared against it each cycle, plus table rows and hand-written sequences.
module tb_decode_stream_ctrl;

    localparam int IN_W      = 32;
    localparam int IN_AW     = 6;
    localparam int OUT_W     = 8;
    localparam int OUT_DEPTH = 128;
    localparam int OUT_AW    = 7;
    localparam int BLOCK_LEN = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [IN_AW-1:0]  in_words_i;
    logic              in_en_o;
    logic [IN_AW-1:0]  in_addr_o;
    logic [IN_W-1:0]   in_data_i;
    logic [IN_W-1:0]   dec_data_o;
    logic              dec_valid_o;
    logic              dec_ready_i;
    logic [OUT_W-1:0]  dec_samp_i;
    logic              dec_samp_valid_i;
    logic              dec_samp_ready_o;
    logic              out_we_o;
    logic [OUT_AW-1:0] out_addr_o;
    logic [OUT_W-1:0]  out_data_o;
    logic [OUT_AW-1:0] blk_cnt_o;
    logic              busy_o;
    logic              done_o;
    logic              underrun_o;
`ifdef DSC_CHECKSUM_EN
    logic [15:0]       chk_o;
`endif

    decode_stream_ctrl #(
        .IN_W      (IN_W),
        .IN_AW     (IN_AW),
        .OUT_W     (OUT_W),
        .OUT_DEPTH (OUT_DEPTH),
        .OUT_AW    (OUT_AW),
        .BLOCK_LEN (BLOCK_LEN)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .in_words_i       (in_words_i),
        .in_en_o          (in_en_o),
        .in_addr_o        (in_addr_o),
        .in_data_i        (in_data_i),
        .dec_data_o       (dec_data_o),
        .dec_valid_o      (dec_valid_o),
        .dec_ready_i      (dec_ready_i),
        .dec_samp_i       (dec_samp_i),
        .dec_samp_valid_i (dec_samp_valid_i),
        .dec_samp_ready_o (dec_samp_ready_o),
        .out_we_o         (out_we_o),
        .out_addr_o       (out_addr_o),
        .out_data_o       (out_data_o),
        .blk_cnt_o        (blk_cnt_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .underrun_o       (underrun_o)
`ifdef DSC_CHECKSUM_EN
        ,
        .chk_o            (chk_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Encoded-word RAM: data only valid the cycle after a read enable; junk otherwise.
    logic [IN_W-1:0] enc_ram [0:(1<<IN_AW)-1];
    always @(posedge clk_i) begin
        in_data_i <= in_en_o ? enc_ram[in_addr_o] : IN_W'($urandom());
    end

    // Reference model state
    bit          m_busy, m_done, m_under, m_we;
    int          m_words, m_cons, m_acc, m_offer_at;
    logic [OUT_AW-1:0] m_waddr;
    logic [OUT_W-1:0]  m_wdata;
    logic [15:0] m_chk;

    int cyc;
    int n_pass;
    int n_total;
    int n_fetch;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_under = 0; m_we = 0;
        m_words = 0; m_cons = 0; m_acc = 0; m_offer_at = 0;
        m_waddr = '0; m_wdata = '0; m_chk = '0;
    endtask

    task automatic check_outputs();
        bit exp_valid, exp_in_en;
        exp_valid = m_busy && (m_cons < m_words) && (cyc >= m_offer_at);
        exp_in_en = m_busy && (m_cons < m_words) && (cyc == m_offer_at - 2);
        check("busy", busy_o, m_busy);
        check("done", done_o, m_done);
        check("underrun", underrun_o, m_under);
        check("samp_ready", dec_samp_ready_o, m_busy && (m_acc < OUT_DEPTH));
        check("out_we", out_we_o, m_we);
        if (m_we) begin
            check("out_addr", out_addr_o, m_waddr);
            check("out_data", out_data_o, m_wdata);
        end
        check("blk_cnt", blk_cnt_o, m_acc / BLOCK_LEN);
        check("in_en", in_en_o, exp_in_en);
        if (exp_in_en) check("in_addr", in_addr_o, m_cons);
        check("dec_valid", dec_valid_o, exp_valid);
        if (exp_valid) check("dec_data", dec_data_o, enc_ram[m_cons]);
`ifdef DSC_CHECKSUM_EN
        check("chk", chk_o, m_chk);
`endif
        if (in_en_o) n_fetch++;
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model at the edge.
    task automatic cycle(input bit st, input int nw, input bit rdy, input bit sv,
                         input logic [OUT_W-1:0] sd);
        bit hs, acc, busy_pre;
        start_i          = st;
        in_words_i       = IN_AW'(nw);
        dec_ready_i      = rdy;
        dec_samp_valid_i = sv;
        dec_samp_i       = sd;
        check_outputs();
        @(posedge clk_i);
        busy_pre = m_busy;
        hs  = m_busy && (m_cons < m_words) && (cyc >= m_offer_at) && rdy;
        acc = m_busy && (m_acc < OUT_DEPTH) && sv;
        if (m_busy && (m_cons == m_words) && rdy) m_under = 1;
        if (hs) begin
            m_cons++;
            m_offer_at = cyc + 3;
        end
        m_we = acc;
        if (acc) begin
            m_waddr = OUT_AW'(m_acc);
            m_wdata = sd;
            m_chk   = m_chk + 16'(sd);
            m_acc++;
            if (m_acc == OUT_DEPTH) begin
                m_busy = 0;
                m_done = 1;
            end
        end
        if (st && !busy_pre) begin
            m_words = nw; m_cons = 0; m_acc = 0; m_chk = '0;
            m_under = 0; m_done = 0; m_busy = 1;
            m_offer_at = cyc + 3;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    // Run until the model says the frame is complete, then one idle cycle.
    // data_mode < 0 gives random sample data, otherwise that constant.
    task automatic finish_frame(input int rdy_pct, input int sv_pct, input int data_mode);
        int budget;
        logic [OUT_W-1:0] d;
        budget = 0;
        while (!m_done && budget < 3000) begin
            d = (data_mode < 0) ? OUT_W'($urandom()) : OUT_W'(data_mode);
            cycle(0, 0, $urandom_range(99) < rdy_pct, $urandom_range(99) < sv_pct, d);
            budget++;
        end
        check("frame_timeout", budget < 3000, 1'b1);
        cycle(0, 0, 0, 0, '0);
    endtask

    task automatic run_frame(input int nw, input int rdy_pct, input int sv_pct);
        cycle(1, nw, $urandom_range(99) < rdy_pct, 0, '0);
        finish_frame(rdy_pct, sv_pct, -1);
    endtask

    task automatic check_reset_outputs();
        check("rst_in_en", in_en_o, 0);
        check("rst_in_addr", in_addr_o, 0);
        check("rst_dec_data", dec_data_o, 0);
        check("rst_dec_valid", dec_valid_o, 0);
        check("rst_samp_ready", dec_samp_ready_o, 0);
        check("rst_out_we", out_we_o, 0);
        check("rst_out_addr", out_addr_o, 0);
        check("rst_out_data", out_data_o, 0);
        check("rst_blk_cnt", blk_cnt_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_underrun", underrun_o, 0);
`ifdef DSC_CHECKSUM_EN
        check("rst_chk", chk_o, 0);
`endif
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 0; dec_ready_i = 0; dec_samp_valid_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs();
        rst_i = 1'b0;
    endtask

    typedef struct {
        int words;
        int rdy_pct;
        int sv_pct;
        int exp_blk;
        bit exp_under;
        int exp_fetch;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs [5];
        int   f0;

        vecs[0] = '{words: 3,  rdy_pct: 100, sv_pct: 100, exp_blk: 2, exp_under: 1, exp_fetch: 3};
        vecs[1] = '{words: 0,  rdy_pct: 0,   sv_pct: 100, exp_blk: 2, exp_under: 0, exp_fetch: 0};
        vecs[2] = '{words: 0,  rdy_pct: 100, sv_pct: 100, exp_blk: 2, exp_under: 1, exp_fetch: 0};
        vecs[3] = '{words: 63, rdy_pct: 100, sv_pct: 100, exp_blk: 2, exp_under: 0, exp_fetch: 43};
        vecs[4] = '{words: 10, rdy_pct: 100, sv_pct: 50,  exp_blk: 2, exp_under: 1, exp_fetch: 10};

        n_pass = 0; n_total = 0; n_fetch = 0; cyc = 0;
        for (int i = 0; i < (1 << IN_AW); i++) enc_ram[i] = IN_W'($urandom());
        in_words_i = '0;
        dec_samp_i = '0;
        do_reset();

        // Table-driven frames
        for (int i = 0; i < 5; i++) begin
            f0 = n_fetch;
            run_frame(vecs[i].words, vecs[i].rdy_pct, vecs[i].sv_pct);
            check("vec_done", done_o, 1'b1);
            check("vec_busy", busy_o, 1'b0);
            check("vec_blk_cnt", blk_cnt_o, vecs[i].exp_blk);
            check("vec_underrun", underrun_o, vecs[i].exp_under);
            check("vec_fetches", n_fetch - f0, vecs[i].exp_fetch);
        end

        // Decoder stalls in OFFER: word held, no extra RAM read
        cycle(1, 2, 0, 0, '0);
        repeat (2) cycle(0, 0, 0, 0, '0);
        f0 = n_fetch;
        repeat (6) cycle(0, 0, 0, 0, '0);
        check("stall_no_refetch", n_fetch - f0, 0);
        check("stall_valid_held", dec_valid_o, 1'b1);
        check("stall_data_held", dec_data_o, enc_ram[0]);
        finish_frame(100, 100, -1);

        // start_i while busy is ignored
        cycle(1, 20, 1, 0, '0);
        repeat (30) cycle(0, 0, 1, 1, OUT_W'($urandom()));
        cycle(1, 5, 1, 1, OUT_W'($urandom()));
        check("start_busy_ignored", busy_o, 1'b1);
        check("start_busy_blk_cnt", blk_cnt_o, 0);
        finish_frame(100, 100, -1);

        // Reset mid-frame after at least 10 words and 100 samples, then a fresh frame
        cycle(1, 40, 1, 0, '0);
        while (m_acc < 100) cycle(0, 0, 1, 1, OUT_W'($urandom()));
        check("pre_reset_words", m_cons >= 10, 1'b1);
        do_reset();
        run_frame(12, 80, 90);
        check("post_reset_done", done_o, 1'b1);
        check("post_reset_blk_cnt", blk_cnt_o, 2);

        // Constant 0xFF samples: checksum and plain frame behaviour
        cycle(1, 4, 1, 0, '0);
        finish_frame(100, 100, 8'hFF);
`ifdef DSC_CHECKSUM_EN
        check("chk_all_ff", chk_o, 16'h7F80);
`endif
        check("ff_frame_last_data", out_data_o, 8'hFF);

        // Randomized frames against the model
        for (int i = 0; i < 6; i++) begin
            run_frame($urandom_range(0, 40), $urandom_range(0, 100), $urandom_range(30, 100));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
